// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC datapath.
package cordic_pkg;

    localparam int CORDIC_DATA_WIDTH    = 16;
    localparam int CORDIC_DATA_OP_WIDTH = 18;
    localparam int CORDIC_FUNC_WIDTH    = 1;
    localparam int CORDIC_NUM_DATA      = 3;

    localparam int CORDIC_IDX_X = 2;
    localparam int CORDIC_IDX_Y = 1;
    localparam int CORDIC_IDX_Z = 0;

    // 1/K in Q1.15 (0.60725)
    localparam int CORDIC_GAIN_COMP = 19898;

    // Width of the gain-compensation product and of the saturation input
    localparam int CORDIC_PROD_WIDTH = CORDIC_DATA_OP_WIDTH + 16;

    localparam logic signed [CORDIC_PROD_WIDTH-1:0] CORDIC_SAT_MAX =
        CORDIC_PROD_WIDTH'((2 ** (CORDIC_DATA_WIDTH - 1)) - 1);
    localparam logic signed [CORDIC_PROD_WIDTH-1:0] CORDIC_SAT_MIN =
        CORDIC_PROD_WIDTH'(-(2 ** (CORDIC_DATA_WIDTH - 1)));

    typedef struct packed {
        logic                         sat;
        logic [CORDIC_DATA_WIDTH-1:0] val;
    } sat_res_t;

    // Clamp a wide signed value into the DATA_WIDTH signed range, flagging clipping
    function automatic sat_res_t sat_to_dw(input logic signed [CORDIC_PROD_WIDTH-1:0] v);
        sat_res_t r;
        r.sat = 1'b0;
        r.val = v[CORDIC_DATA_WIDTH-1:0];
        if (v > CORDIC_SAT_MAX) begin
            r.sat = 1'b1;
            r.val = {1'b0, {(CORDIC_DATA_WIDTH-1){1'b1}}};
        end else if (v < CORDIC_SAT_MIN) begin
            r.sat = 1'b1;
            r.val = {1'b1, {(CORDIC_DATA_WIDTH-1){1'b0}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// Result FIFO: first-word-fall-through head, registered almost-full and sticky overflow.
module cordic_sync_fifo
    import cordic_pkg::*;
#(
    parameter int WIDTH        = 50,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_vld,
    output logic             o_afull,
    output logic             o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(AFULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             pop;
    logic             push;
    logic             drop;

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign pop  = i_rd && (count != '0);
    assign push = i_wr && ((count < DEPTH_C) || pop);
    assign drop = i_wr && !push;

    assign o_vld   = (count != '0);
    assign o_rdata = o_vld ? mem[rd_ptr] : '0;

    // Next occupancy, also used so o_afull moves in step with count
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_afull <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_nxt;
            o_afull <= ((DEPTH_C - count_nxt) <= THRESH_C);
            if (drop) begin
                o_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_output_stage.sv
// CORDIC back end: 1/K gain compensation, rounding, saturation and result buffering.
module cordic_output_stage
    import cordic_pkg::*;
#(
    parameter int EN_SCALE      = 1,
    parameter int NUM_DATA      = CORDIC_NUM_DATA,
    parameter int FUNC_WIDTH    = CORDIC_FUNC_WIDTH,
    parameter int DATA_WIDTH    = CORDIC_DATA_WIDTH,
    parameter int DATA_OP_WIDTH = CORDIC_DATA_OP_WIDTH,
    parameter int GAIN_COMP     = CORDIC_GAIN_COMP,
    parameter int FIFO_DEPTH    = 4,
    parameter int AFULL_THRESH  = 2
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_vld,
    input  logic [NUM_DATA*DATA_OP_WIDTH+FUNC_WIDTH-1:0] i_data,
    output logic                                     o_vld,
    input  logic                                     i_rdy,
    output logic [NUM_DATA*DATA_WIDTH+FUNC_WIDTH-1:0]    o_data,
    output logic                                     o_sat,
    output logic                                     o_afull,
    output logic                                     o_ovf
);

    localparam int IN_W  = NUM_DATA*DATA_OP_WIDTH + FUNC_WIDTH;
    localparam int OUT_W = NUM_DATA*DATA_WIDTH + FUNC_WIDTH;
    localparam int PW    = CORDIC_PROD_WIDTH;

    localparam logic signed [PW-1:0] GAIN_S  = PW'(GAIN_COMP);
    localparam logic signed [PW-1:0] ROUND_S = PW'(1 << 14);

    logic signed [DATA_OP_WIDTH-1:0] in_f [NUM_DATA];
    logic signed [PW-1:0]            s1_p_nxt [NUM_DATA];

    logic                    s1_vld;
    logic [FUNC_WIDTH-1:0]   s1_func;
    logic signed [PW-1:0]    s1_p [NUM_DATA];

    logic [OUT_W-1:0]        s2_data_nxt;
    logic                    s2_sat_nxt;
    logic                    s2_vld;
    logic [OUT_W-1:0]        s2_data;
    logic                    s2_sat;

    logic [OUT_W:0]          fifo_rdata;

    for (genvar g = 0; g < NUM_DATA; g++) begin : g_field
        assign in_f[g] = i_data[g*DATA_OP_WIDTH +: DATA_OP_WIDTH];
    end

    // S1 operands: X/Y become Q.15 products, other fields pass through sign-extended
    always_comb begin
        for (int k = 0; k < NUM_DATA; k++) begin
            s1_p_nxt[k] = PW'(in_f[k]);
            if ((k == CORDIC_IDX_X) || (k == CORDIC_IDX_Y)) begin
                if (EN_SCALE != 0) begin
                    s1_p_nxt[k] = PW'(in_f[k]) * GAIN_S;
                end else begin
                    s1_p_nxt[k] = PW'(in_f[k]) <<< 15;
                end
            end
        end
    end

    // S1 register stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld  <= 1'b0;
            s1_func <= '0;
            s1_p    <= '{default: '0};
        end else begin
            s1_vld <= i_vld;
            if (i_vld) begin
                s1_func <= i_data[IN_W-1 -: FUNC_WIDTH];
                s1_p    <= s1_p_nxt;
            end
        end
    end

    // S2 arithmetic: round X/Y half up out of Q.15, then clamp every field
    always_comb begin
        logic signed [PW-1:0] v;
        sat_res_t             r;
        s2_data_nxt = '0;
        s2_sat_nxt  = 1'b0;
        s2_data_nxt[OUT_W-1 -: FUNC_WIDTH] = s1_func;
        for (int k = 0; k < NUM_DATA; k++) begin
            v = s1_p[k];
            if ((k == CORDIC_IDX_X) || (k == CORDIC_IDX_Y)) begin
                v = (s1_p[k] + ROUND_S) >>> 15;
            end
            r = sat_to_dw(v);
            s2_data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = r.val;
            s2_sat_nxt = s2_sat_nxt | r.sat;
        end
    end

    // S2 register stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_vld  <= 1'b0;
            s2_data <= '0;
            s2_sat  <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_data <= s2_data_nxt;
                s2_sat  <= s2_sat_nxt;
            end
        end
    end

    cordic_sync_fifo #(
        .WIDTH        (OUT_W + 1),
        .DEPTH        (FIFO_DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (s2_vld),
        .i_wdata ({s2_sat, s2_data}),
        .i_rd    (i_rdy),
        .o_rdata (fifo_rdata),
        .o_vld   (o_vld),
        .o_afull (o_afull),
        .o_ovf   (o_ovf)
    );

    assign o_sat  = fifo_rdata[OUT_W];
    assign o_data = fifo_rdata[OUT_W-1:0];

endmodule

// File: tb/tb_cordic_output_stage.sv
// Directed and scoreboarded checks for cordic_output_stage.
module tb_cordic_output_stage;

    logic        clk;
    logic        rst;
    logic        vld;
    logic [54:0] data;
    logic        rdy;
    logic        o_vld;
    logic [48:0] o_data;
    logic        o_sat;
    logic        o_afull;
    logic        o_ovf;

    int total;
    int bad;

    cordic_output_stage dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_vld   (vld),
        .i_data  (data),
        .o_vld   (o_vld),
        .i_rdy   (rdy),
        .o_data  (o_data),
        .o_sat   (o_sat),
        .o_afull (o_afull),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [54:0] pack_in(int f, int x, int y, int z);
        return {f[0], x[17:0], y[17:0], z[17:0]};
    endfunction

    // Reference: {sat, func, x, y, z} from real-number semantics of the stage
    function automatic logic [49:0] model(int f, int x, int y, int z);
        longint r [3];
        logic   s;
        logic [48:0] d;
        s = 1'b0;
        r[2] = (longint'(x) * 19898 + 16384) >>> 15;
        r[1] = (longint'(y) * 19898 + 16384) >>> 15;
        r[0] = longint'(z);
        d = '0;
        d[48] = f[0];
        for (int k = 0; k < 3; k++) begin
            if (r[k] > 32767) begin
                s = 1'b1;
                r[k] = 32767;
            end else if (r[k] < -32768) begin
                s = 1'b1;
                r[k] = -32768;
            end
            d[k*16 +: 16] = r[k][15:0];
        end
        return {s, d};
    endfunction

    function automatic logic [48:0] zbeat(int f, int z);
        return {f[0], 16'd0, 16'd0, z[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b exp=0", o_vld); end
        total++; if (o_data !== 49'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", o_data); end
        total++; if (o_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%0b exp=0", o_sat); end
        total++; if (o_afull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%0b exp=0", o_afull); end
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", o_ovf); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        rdy  = 1'b1;
        vld  = 1'b1;
        data = pack_in(1, 16384, 0, -5);
        tick();
        vld = 1'b0;
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL lat_edge1 got=%0b exp=0", o_vld); end
        tick();
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL lat_edge2 got=%0b exp=0", o_vld); end
        tick();
        total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL lat_edge3 got=%0b exp=1", o_vld); end
        total++; if (o_data !== {1'b1, 16'd9949, 16'd0, 16'hFFFB}) begin
            bad++; $display("FAIL lat_data got=%h exp=%h", o_data, {1'b1, 16'd9949, 16'd0, 16'hFFFB});
        end
        total++; if (o_sat !== 1'b0) begin bad++; $display("FAIL lat_sat got=%0b exp=0", o_sat); end
        tick();
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL lat_popped got=%0b exp=0", o_vld); end
    endtask

    task automatic test_saturate();
        logic [48:0] exp_d [3];
        logic        exp_s [3];
        exp_d[0] = {1'b0, 16'h7FFF, 16'h8000, 16'h7FFF}; exp_s[0] = 1'b1;
        exp_d[1] = {1'b1, 16'hD923, 16'h0002, 16'h8000}; exp_s[1] = 1'b1;
        exp_d[2] = {1'b0, 16'h0001, 16'hFFFF, 16'h7FFF}; exp_s[2] = 1'b0;
        rdy = 1'b1;
        vld = 1'b1;
        data = pack_in(0, 131071, -131072, 40000);
        tick();
        data = pack_in(1, -16384, 3, -40000);
        tick();
        data = pack_in(0, 1, -1, 32767);
        tick();
        vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (o_vld !== 1'b1 || o_data !== exp_d[i]) begin
                bad++; $display("FAIL sat_data%0d got=%b/%h exp=1/%h", i, o_vld, o_data, exp_d[i]);
            end
            total++; if (o_sat !== exp_s[i]) begin
                bad++; $display("FAIL sat_flag%0d got=%0b exp=%0b", i, o_sat, exp_s[i]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vld  = 1'b1;
            data = pack_in(k & 1, 0, 0, 10 * (k + 1));
            tick();
            vld = 1'b0;
            tick(); tick(); tick();
            if (k == 0) begin
                total++; if (o_afull !== 1'b0) begin bad++; $display("FAIL ovf_afull1 got=%0b exp=0", o_afull); end
            end
            if (k == 1) begin
                total++; if (o_afull !== 1'b1) begin bad++; $display("FAIL ovf_afull2 got=%0b exp=1", o_afull); end
            end
            if (k == 3) begin
                total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", o_ovf); end
                total++; if (o_data !== zbeat(0, 10)) begin
                    bad++; $display("FAIL ovf_hold got=%h exp=%h", o_data, zbeat(0, 10));
                end
            end
        end
        total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", o_ovf); end
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (o_vld !== 1'b1 || o_data !== zbeat(k & 1, 10 * (k + 1))) begin
                bad++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", k, o_vld, o_data, zbeat(k & 1, 10 * (k + 1)));
            end
            tick();
        end
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b exp=0", o_vld); end
    endtask

    task automatic test_full_push_pop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vld  = (i < 5);
            data = pack_in(0, 0, 0, 101 + i);
            rdy  = (i == 6);
            tick();
        end
        vld = 1'b0;
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%0b exp=0", o_ovf); end
        total++; if (o_afull !== 1'b1) begin bad++; $display("FAIL pp_afull got=%0b exp=1", o_afull); end
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (o_vld !== 1'b1 || o_data !== zbeat(0, 102 + k)) begin
                bad++; $display("FAIL pp_drain%0d got=%b/%h exp=1/%h", k, o_vld, o_data, zbeat(0, 102 + k));
            end
            tick();
        end
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL pp_empty got=%0b exp=0", o_vld); end
    endtask

    task automatic test_back_to_back();
        logic [49:0] q [$];
        logic [49:0] exp_v;
        int sent;
        int popped;
        int x, y, z, f;
        sent   = 0;
        popped = 0;
        for (int cyc = 0; cyc < 3000 && popped < 100; cyc++) begin
            rdy = ($urandom_range(0, 99) < 70);
            if (o_vld && rdy) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b2b_unexpected got=%h exp=none", o_data);
                end else begin
                    exp_v = q.pop_front();
                    total++; if ({o_sat, o_data} !== exp_v) begin
                        bad++; $display("FAIL b2b_beat%0d got=%h exp=%h", popped, {o_sat, o_data}, exp_v);
                    end
                end
                popped++;
            end
            if (sent < 100 && !o_afull) begin
                f = int'($urandom_range(0, 1));
                x = int'($urandom_range(0, 262143)) - 131072;
                y = int'($urandom_range(0, 262143)) - 131072;
                z = int'($urandom_range(0, 262143)) - 131072;
                if (sent % 3 == 0) begin
                    x = x / 8;
                    y = y / 8;
                    z = z / 8;
                end
                vld  = 1'b1;
                data = pack_in(f, x, y, z);
                q.push_back(model(f, x, y, z));
                sent++;
            end else begin
                vld = 1'b0;
            end
            tick();
        end
        vld = 1'b0;
        total++; if (popped != 100) begin bad++; $display("FAIL b2b_count got=%0d exp=100", popped); end
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%0b exp=0", o_ovf); end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vld  = 1'b1;
            data = pack_in(1, 0, 0, 200 + i);
            tick();
        end
        vld = 1'b0;
        total++; if (o_ovf !== 1'b1 || o_vld !== 1'b1) begin
            bad++; $display("FAIL rst_pre got=%0b%0b exp=11", o_ovf, o_vld);
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%0b exp=0", o_vld); end
        total++; if (o_data !== 49'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", o_data); end
        total++; if (o_sat !== 1'b0) begin bad++; $display("FAIL rst_sat got=%0b exp=0", o_sat); end
        total++; if (o_afull !== 1'b0) begin bad++; $display("FAIL rst_afull got=%0b exp=0", o_afull); end
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b exp=0", o_ovf); end
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL rst_flushed got=%0b exp=0", o_vld); end
        rdy  = 1'b1;
        vld  = 1'b1;
        data = pack_in(0, -16384, 16384, 7);
        tick();
        vld = 1'b0;
        tick();
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL rst_lat2 got=%0b exp=0", o_vld); end
        tick();
        total++; if (o_vld !== 1'b1 || o_data !== {1'b0, 16'hD923, 16'd9949, 16'd7}) begin
            bad++; $display("FAIL rst_lat3 got=%b/%h exp=1/%h", o_vld, o_data, {1'b0, 16'hD923, 16'd9949, 16'd7});
        end
        tick();
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        vld   = 1'b0;
        data  = '0;
        rdy   = 1'b0;
        total = 0;
        bad   = 0;
        test_reset();
        test_latency();
        test_saturate();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
